count_wrap_monitor: RTL and testbench
=====================================

# count_wrap_monitor

Downstream companion to the 4-bit free-running up counter. It samples the counter's `count` output every clock and extends it to a wider count by tracking 15→0 wraps. It also checks that the stream steps by exactly +1 per clock and flags skips, stalls and extension overflow with sticky status bits. It sits between the counter and any consumer that needs a long-range, integrity-checked count.

## Interface

Parameters:
- `HI_WIDTH`, default 8: width of the wrap (high) counter.
- `STALL_LIMIT`, default 4: consecutive unchanged samples that trigger a stall fault. Legal range is 1..255.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `count` in 4: counter value being monitored.
- `clear` in 1: synchronous; clears sticky faults and re-acquires.
- `ext_count` out 4+HI_WIDTH: `{hi, low}` extended count.
- `valid` out 1: `ext_count` is trustworthy.
- `wrap_pulse` out 1: one-cycle pulse per detected 15→0 wrap.
- `skip_err` out 1: sticky; a non-+1, non-hold step was seen.
- `stall_err` out 1: sticky; `count` held too long.
- `hi_overflow` out 1: sticky; `hi` wrapped from all-ones to 0.

## Operation

- State machine has three states: ACQUIRE, TRACK, FAULT. Reset and clear both enter ACQUIRE.
- **ACQUIRE** (one edge):
  - `prev <= count`, `hi <= 0`, stall counter `<= 0`.
  - `ext_count <= {0, count}`, `valid <= 1`.
  - Next state is TRACK.
- **TRACK**: compare `count` against `prev` on every edge.
  - **Step** (`count == prev+1`, `prev != 15`): `prev <= count`, `ext_count <= {hi, count}`, stall counter cleared.
  - **Wrap** (`prev == 15`, `count == 0`): `hi <= hi+1` modulo 2^HI_WIDTH, `wrap_pulse <= 1`, `ext_count <= {hi+1, 0}`. If `hi` was all-ones, `hi_overflow <= 1`. `valid` stays 1.
  - **Hold** (`count == prev`): nothing updates except the stall counter (see Configuration).
  - **Any other value**: `skip_err <= 1`, `valid <= 0`, `ext_count` frozen, next state FAULT.
- **FAULT**:
  - All outputs are held.
  - `count` is ignored.
  - The block leaves FAULT only on `clear` or `reset`.
- Priority: `reset` > `clear` > normal operation. `clear` in any state clears `skip_err`, `stall_err` and `hi_overflow`, drops `valid` to 0 for that edge's output, and enters ACQUIRE.
- A reset of the upstream counter alone (e.g. 7→0) counts as a skip. The system must reset both blocks together.

## Timing

- Every output is registered.
- Reset values:
  - `ext_count = 0`, `valid = 0`, `wrap_pulse = 0`.
  - All sticky flags = 0.
  - State = ACQUIRE.
- `valid` rises on the first edge with `reset` low. `ext_count` then equals `{0, count}` sampled at that edge.
- Latency is one clock: `ext_count` after edge N reflects `count` sampled at edge N.
- `wrap_pulse` is high for exactly the one cycle following the edge that sampled the 0 after 15.
- Error flags assert on the same edge that samples the offending value.
- A wrap and an `hi` overflow on the same edge set `wrap_pulse` and `hi_overflow` together.
- `clear` asserted together with a fault condition: `clear` wins, and no flag is set on that edge.

## Configuration

- Macro: `STALL_DETECT_EN`.
- **Defined**:
  - An 8-bit stall counter increments on each Hold sample and is cleared on Step or Wrap.
  - When it reaches `STALL_LIMIT`, i.e. on the `STALL_LIMIT`-th consecutive hold, `stall_err <= 1`, `valid <= 0` and the state goes to FAULT.
- **Undefined**:
  - Holds are legal indefinitely.
  - No stall counter is built.
  - `stall_err` is tied to 0.

## Test plan

1. Reset for 2 cycles, then a free-running count 0..15,0 → `valid` = 1 after the first post-reset edge, `ext_count` tracks 0x000..0x00F, then reads 0x010 with `wrap_pulse` high for one cycle (HI_WIDTH=8).
2. 40 clean steps from 0 → `ext_count` = 0x028, two `wrap_pulse`s seen, no flags set.
3. Force `count` 5→7 → `skip_err` = 1 and `valid` = 0 on that edge, `ext_count` frozen at 0x005. Pulse `clear` with `count` = 9 → `valid` = 1, `ext_count` = 0x009, `skip_err` = 0.
4. With `STALL_DETECT_EN` and STALL_LIMIT=4, hold `count` at 9:
   - 3 holds → no error.
   - 4th hold → `stall_err` = 1, `valid` = 0.
   - Without the macro, 20 holds → no error and `valid` stays 1.
5. HI_WIDTH=2, 4 full wraps → `hi` returns to 0, `hi_overflow` = 1, `valid` stays 1, `ext_count` = 0x00 on the 4th wrap.
6. Assert `reset` while in FAULT → all outputs return to reset values. The first edge after release re-acquires with `hi` = 0.

Source files
------------

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: extends a 4-bit free-running count by tracking 15->0 wraps
// and flags skips, stalls (macro STALL_DETECT_EN) and high-counter overflow.
`default_nettype none

module count_wrap_monitor #(
  parameter int HI_WIDTH    = 8,
  parameter int STALL_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            count,
  input  logic                  clear,
  output logic [HI_WIDTH+3:0]   ext_count,
  output logic                  valid,
  output logic                  wrap_pulse,
  output logic                  skip_err,
  output logic                  stall_err,
  output logic                  hi_overflow
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            prev, prev_nxt;
  logic [HI_WIDTH-1:0]   hi, hi_nxt, hi_inc;
  logic [HI_WIDTH+3:0]   ext_nxt;
  logic                  valid_nxt, wrap_nxt, skip_nxt, ovf_nxt;
  logic                  is_step, is_wrap, is_hold;

  assign hi_inc  = hi + {{(HI_WIDTH-1){1'b0}}, 1'b1};
  assign is_wrap = (prev == 4'd15) && (count == 4'd0);
  assign is_step = (prev != 4'd15) && (count == prev + 4'd1);
  assign is_hold = (count == prev);

`ifdef STALL_DETECT_EN
  localparam logic [8:0] STALL_LIM9 = 9'(STALL_LIMIT);
  logic [7:0] stall_cnt;
  logic       stall_hit;
  logic       stall_nxt;

  // stall_hit marks the sample that would be the STALL_LIMIT-th consecutive hold
  assign stall_hit = (({1'b0, stall_cnt} + 9'd1) == STALL_LIM9);

  always_ff @(posedge clk) begin
    if (reset || clear || state != TRACK) begin
      stall_cnt <= 8'd0;
    end else if (is_hold) begin
      stall_cnt <= stall_cnt + 8'd1;
    end else begin
      stall_cnt <= 8'd0;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    hi_nxt    = hi;
    ext_nxt   = ext_count;
    valid_nxt = valid;
    wrap_nxt  = 1'b0;
    skip_nxt  = skip_err;
    ovf_nxt   = hi_overflow;
`ifdef STALL_DETECT_EN
    stall_nxt = stall_err;
`endif
    if (clear) begin
      state_nxt = ACQUIRE;
      valid_nxt = 1'b0;
      skip_nxt  = 1'b0;
      ovf_nxt   = 1'b0;
`ifdef STALL_DETECT_EN
      stall_nxt = 1'b0;
`endif
    end else begin
      case (state)
        ACQUIRE: begin
          prev_nxt  = count;
          hi_nxt    = '0;
          ext_nxt   = {{HI_WIDTH{1'b0}}, count};
          valid_nxt = 1'b1;
          state_nxt = TRACK;
        end
        TRACK: begin
          if (is_wrap) begin
            prev_nxt = count;
            hi_nxt   = hi_inc;
            ext_nxt  = {hi_inc, 4'd0};
            wrap_nxt = 1'b1;
            if (hi == {HI_WIDTH{1'b1}}) ovf_nxt = 1'b1;
          end else if (is_step) begin
            prev_nxt = count;
            ext_nxt  = {hi, count};
          end else if (is_hold) begin
`ifdef STALL_DETECT_EN
            if (stall_hit) begin
              stall_nxt = 1'b1;
              valid_nxt = 1'b0;
              state_nxt = FAULT;
            end
`endif
          end else begin
            skip_nxt  = 1'b1;
            valid_nxt = 1'b0;
            state_nxt = FAULT;
          end
        end
        default: begin
          state_nxt = FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACQUIRE;
      prev        <= 4'd0;
      hi          <= '0;
      ext_count   <= '0;
      valid       <= 1'b0;
      wrap_pulse  <= 1'b0;
      skip_err    <= 1'b0;
      hi_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      hi          <= hi_nxt;
      ext_count   <= ext_nxt;
      valid       <= valid_nxt;
      wrap_pulse  <= wrap_nxt;
      skip_err    <= skip_nxt;
      hi_overflow <= ovf_nxt;
    end
  end

`ifdef STALL_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_err <= 1'b0;
    end else begin
      stall_err <= stall_nxt;
    end
  end
`else
  assign stall_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
// Scoreboard bench for count_wrap_monitor: default instance (HI_WIDTH=8) and a HI_WIDTH=2 instance.
`default_nettype none

module tb_count_wrap_monitor;

  typedef struct {
    logic [11:0] ext;
    logic        valid;
    logic        wrap;
    logic        skip;
    logic        stall;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0;
  logic [3:0]  count = 4'd0;
  logic        reset2 = 1'b1;
  logic [3:0]  count2 = 4'd0;

  logic [11:0] ext_count;
  logic        valid, wrap_pulse, skip_err, stall_err, hi_overflow;
  logic [5:0]  ext_count2;
  logic        valid2, wrap_pulse2, skip_err2, stall_err2, hi_overflow2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   idx1 = 0;
  int   idx2 = 0;

  always #5 clk = ~clk;

  count_wrap_monitor #(.HI_WIDTH(8), .STALL_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .count(count), .clear(clear),
    .ext_count(ext_count), .valid(valid), .wrap_pulse(wrap_pulse),
    .skip_err(skip_err), .stall_err(stall_err), .hi_overflow(hi_overflow)
  );

  count_wrap_monitor #(.HI_WIDTH(2), .STALL_LIMIT(4)) dut2 (
    .clk(clk), .reset(reset2), .count(count2), .clear(1'b0),
    .ext_count(ext_count2), .valid(valid2), .wrap_pulse(wrap_pulse2),
    .skip_err(skip_err2), .stall_err(stall_err2), .hi_overflow(hi_overflow2)
  );

  function automatic exp_t mk(input int ext, input bit v, input bit w,
                              input bit sk, input bit st, input bit ov);
    exp_t e;
    e.ext = 12'(ext); e.valid = v; e.wrap = w; e.skip = sk; e.stall = st; e.ovf = ov;
    return e;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic c, input int cnt, input exp_t e);
    @(negedge clk);
    reset = r; clear = c; count = 4'(cnt);
    q1.push_back(e);
    @(posedge clk);
  endtask

  task automatic drive2(input logic r, input int cnt, input exp_t e);
    @(negedge clk);
    reset2 = r; count2 = 4'(cnt);
    q2.push_back(e);
    @(posedge clk);
  endtask

  // Monitors: pop one expectation per edge that has one queued
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("ext_count",   idx1, ext_count, e.ext);
      chk("valid",       idx1, {11'd0, valid}, {11'd0, e.valid});
      chk("wrap_pulse",  idx1, {11'd0, wrap_pulse}, {11'd0, e.wrap});
      chk("skip_err",    idx1, {11'd0, skip_err}, {11'd0, e.skip});
      chk("stall_err",   idx1, {11'd0, stall_err}, {11'd0, e.stall});
      chk("hi_overflow", idx1, {11'd0, hi_overflow}, {11'd0, e.ovf});
      idx1++;
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk("w2_ext_count",   idx2, {6'd0, ext_count2}, {6'd0, e.ext[5:0]});
      chk("w2_valid",       idx2, {11'd0, valid2}, {11'd0, e.valid});
      chk("w2_wrap_pulse",  idx2, {11'd0, wrap_pulse2}, {11'd0, e.wrap});
      chk("w2_skip_err",    idx2, {11'd0, skip_err2}, {11'd0, e.skip});
      chk("w2_hi_overflow", idx2, {11'd0, hi_overflow2}, {11'd0, e.ovf});
      idx2++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = mk(0, 0, 0, 0, 0, 0);

    // Reset, then 0..15 and the first wrap
    drive(1, 0, 0, z);
    drive(1, 0, 0, z);
    for (int i = 0; i < 16; i++) drive(0, 0, i, mk(i, 1, 0, 0, 0, 0));
    drive(0, 0, 0, mk(12'h010, 1, 1, 0, 0, 0));
    drive(0, 0, 1, mk(12'h011, 1, 0, 0, 0, 0));

    // 40 clean steps from 0
    drive(1, 0, 0, z);
    for (int k = 0; k <= 40; k++)
      drive(0, 0, k % 16, mk(k, 1, (k > 0) && (k % 16 == 0), 0, 0, 0));

    // Skip 5 -> 7, fault hold, clear, re-acquire at 9
    drive(1, 0, 0, z);
    for (int k = 0; k <= 5; k++) drive(0, 0, k, mk(k, 1, 0, 0, 0, 0));
    drive(0, 0, 7, mk(5, 0, 0, 1, 0, 0));
    drive(0, 0, 3, mk(5, 0, 0, 1, 0, 0));
    drive(0, 1, 9, mk(5, 0, 0, 0, 0, 0));
    drive(0, 0, 9, mk(9, 1, 0, 0, 0, 0));

`ifdef STALL_DETECT_EN
    for (int h = 1; h <= 3; h++) drive(0, 0, 9, mk(9, 1, 0, 0, 0, 0));
    drive(0, 0, 9, mk(9, 0, 0, 0, 1, 0));
    drive(0, 0, 4, mk(9, 0, 0, 0, 1, 0));
`else
    for (int h = 1; h <= 20; h++) drive(0, 0, 9, mk(9, 1, 0, 0, 0, 0));
    drive(0, 0, 2, mk(9, 0, 0, 1, 0, 0));
`endif

    // Reset out of FAULT, re-acquire, then clear colliding with a skip value
    drive(1, 0, 2, z);
    drive(0, 0, 5, mk(5, 1, 0, 0, 0, 0));
    drive(0, 0, 6, mk(6, 1, 0, 0, 0, 0));
    drive(0, 1, 12, mk(6, 0, 0, 0, 0, 0));
    drive(0, 0, 12, mk(12, 1, 0, 0, 0, 0));
    drive(0, 0, 13, mk(13, 1, 0, 0, 0, 0));

    // HI_WIDTH=2 instance: four full wraps overflow hi back to 0
    drive2(1, 0, z);
    for (int k = 0; k <= 65; k++)
      drive2(0, k % 16, mk(((k / 16) % 4) * 16 + (k % 16), 1,
                           (k > 0) && (k % 16 == 0), 0, 0, k >= 64));

    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", 0, 12'(q1.size() + q2.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
